demux_32b_1b2_buf: RTL
======================

DEMUX_32B_1B2_BUF -- requirements
Module: demux_32b_1b2_buf

Interface
REQ-001 Parameter: WIDTH, 32, data width of input and both outputs.
REQ-002 Parameter: DEPTH, 2, entries per output queue; fixed at 2, other values unsupported.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: s  input  1  destination select for the current input word (0 -> channel 0, 1 -> channel 1).
REQ-006 Port: data_in  input  WIDTH  input word.
REQ-007 Port: in_valid  input  1  data_in and s are valid this cycle.
REQ-008 Port: in_ready  output  1  block accepts the input word this cycle.
REQ-009 Port: data_out_0 / data_out_1  output  WIDTH  head word of queue 0 / 1.
REQ-010 Port: out_valid_0 / out_valid_1  output  1  queue 0 / 1 is non-empty.
REQ-011 Port: out_ready_0 / out_ready_1  input  1  consumer 0 / 1 takes the head word.
REQ-012 Port: count_0 / count_1  output  2  occupancy of queue 0 / 1 (0..2).

Function
REQ-013 The block SHALL route each accepted input word into exactly one of two independent 2-entry FIFO queues selected by s.
REQ-014 Accept: the word SHALL be accepted when in_valid && in_ready at a rising edge.
REQ-015 in_ready SHALL be combinational: in_ready = (s ? count_1 : count_0) != 2; independent of in_valid.
REQ-016 Backpressure on one queue SHALL NOT block words whose s selects the other non-full queue.
REQ-017 out_valid_N SHALL equal (count_N != 0); data_out_N SHALL present the oldest stored word of queue N.
REQ-018 Pop: the head of queue N SHALL be removed when out_valid_N && out_ready_N at a rising edge; out_ready_N while empty has no effect.
REQ-019 Latency: a word accepted into an empty queue SHALL appear on data_out_N with out_valid_N high in the next cycle; no combinational input-to-output path.
REQ-020 Ordering: each queue SHALL preserve acceptance order; no word SHALL be lost, duplicated or delivered to the wrong channel.
REQ-021 Simultaneous push and pop on the same queue (count 1) SHALL leave count unchanged and the pushed word behind the new head.
REQ-022 Simultaneous push and pop on the same queue at count 2 SHALL NOT occur (in_ready low); pop alone reduces count to 1.
REQ-023 Push on one queue and pop on the other in the same cycle SHALL both complete.
REQ-024 Read/write pointers SHALL be 1 bit per queue and wrap 1 -> 0; count SHALL be 0..2 only.
REQ-025 data_out_N when out_valid_N is low SHALL be 0 (storage of popped slot is not required to clear; output is gated).

Reset
REQ-026 On rst_n low, asynchronously: count_0 = count_1 = 0, all pointers 0, out_valid_0 = out_valid_1 = 0, data_out_0 = data_out_1 = 0, storage cleared to 0.
REQ-027 in_ready SHALL be 1 while in reset regardless of s (both queues empty); words presented during reset SHALL NOT be stored.
REQ-028 Reset asserted mid-operation SHALL discard all queued words; first accepted word after release SHALL be the first one delivered.

Verification
REQ-029 Reset, then s=0 data_in=100 in_valid=1 one cycle, out_ready_0=0 -> next cycle out_valid_0=1, data_out_0=100, count_0=1, out_valid_1=0.
REQ-030 s=1 push 50 then 100, out_ready_1=0 -> count_1=2, in_ready=0 while s=1, in_ready=1 when s=0; push 200 on s=0 accepted, count_0 increments.
REQ-031 Queue 1 holding {50,100}, out_ready_1=1 for two cycles -> data_out_1 sequence 50, 100, then out_valid_1=0, data_out_1=0, count_1=0.
REQ-032 Queue 0 count 1 (head 100), push 200 on s=0 with out_ready_0=1 same cycle -> count_0 stays 1, data_out_0=200 next cycle.
REQ-033 Queues loaded (count_0=2, count_1=1), rst_n pulsed low mid-cycle -> all counts/valids/data outputs 0 immediately; after release push 300 on s=1 -> data_out_1=300 next cycle.
REQ-034 Random stimulus, 10k cycles, random s/in_valid/out_ready -> scoreboard per channel: order preserved, no loss, no cross-routing, count matches model every cycle.

Source files
------------

// File: rtl/demux_32b_1b2_buf.sv
// -----------------------------------------------------------------------------
// demux_32b_1b2_buf
// Routes each accepted input word into one of two independent 2-entry FIFO
// queues. The queue is selected by s. Each queue has its own ready/valid
// consumer handshake.
//
// Ports
//   clk          : single clock, rising-edge state updates
//   rst_n        : asynchronous active-low reset (clears counts, pointers, storage)
//   s            : destination select for data_in (0 -> queue 0, 1 -> queue 1)
//   data_in      : input word
//   in_valid     : data_in / s are valid this cycle
//   in_ready     : selected queue is not full (combinational on s)
//   data_out_0/1 : head word of queue 0/1, forced to 0 while the queue is empty
//   out_valid_0/1: queue 0/1 is non-empty
//   out_ready_0/1: consumer 0/1 takes the head word
//   count_0/1    : occupancy of queue 0/1 (0..2)
// -----------------------------------------------------------------------------
module demux_32b_1b2_buf #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s,
   input  logic [WIDTH-1:0] data_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] data_out_0,
   output logic [WIDTH-1:0] data_out_1,
   output logic             out_valid_0,
   output logic             out_valid_1,
   input  logic             out_ready_0,
   input  logic             out_ready_1,
   output logic [1:0]       count_0,
   output logic [1:0]       count_1
);

   // Storage is addressed by 1-bit pointers, so only DEPTH == 2 is supported.
   localparam logic [1:0] FULL = 2'(DEPTH);

   logic [WIDTH-1:0] mem_q    [2][2];
   logic [1:0]       cnt_q    [2];
   logic [1:0]       cnt_d    [2];
   logic             wr_ptr_q [2];
   logic             wr_ptr_d [2];
   logic             rd_ptr_q [2];
   logic             rd_ptr_d [2];
   logic [1:0]       push;
   logic [1:0]       pop;
   logic [1:0]       ready_ch;
   logic             pop_req [2];

   assign pop_req[0] = out_ready_0;
   assign pop_req[1] = out_ready_1;

   // Per-queue not-full. in_ready looks only at the queue that s selects.
   // A full queue therefore never stalls words aimed at the other queue.
   assign ready_ch[0] = (cnt_q[0] != FULL);
   assign ready_ch[1] = (cnt_q[1] != FULL);
   assign in_ready    = s ? ready_ch[1] : ready_ch[0];

   always_comb begin
      push = '0;
      pop  = '0;
      for (int c = 0; c < 2; c++) begin
         cnt_d[c]    = cnt_q[c];
         wr_ptr_d[c] = wr_ptr_q[c];
         rd_ptr_d[c] = rd_ptr_q[c];
      end

      push[0] = in_valid && ready_ch[0] && !s;
      push[1] = in_valid && ready_ch[1] &&  s;

      for (int c = 0; c < 2; c++) begin
         // Popping an empty queue is ignored.
         pop[c]      = pop_req[c] && (cnt_q[c] != 2'd0);
         wr_ptr_d[c] = wr_ptr_q[c] ^ push[c];
         rd_ptr_d[c] = rd_ptr_q[c] ^ pop[c];
         // A simultaneous push and pop leaves the occupancy unchanged.
         case ({push[c], pop[c]})
            2'b10:   cnt_d[c] = cnt_q[c] + 2'd1;
            2'b01:   cnt_d[c] = cnt_q[c] - 2'd1;
            default: cnt_d[c] = cnt_q[c];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 2; c++) begin
            cnt_q[c]    <= 2'd0;
            wr_ptr_q[c] <= 1'b0;
            rd_ptr_q[c] <= 1'b0;
            mem_q[c][0] <= '0;
            mem_q[c][1] <= '0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            cnt_q[c]    <= cnt_d[c];
            wr_ptr_q[c] <= wr_ptr_d[c];
            rd_ptr_q[c] <= rd_ptr_d[c];
            if (push[c]) begin
               mem_q[c][wr_ptr_q[c]] <= data_in;
            end
         end
      end
   end

   // Outputs come only from registers. A popped slot keeps its old contents,
   // so the head is gated to 0 whenever the queue is empty.
   assign count_0     = cnt_q[0];
   assign count_1     = cnt_q[1];
   assign out_valid_0 = (cnt_q[0] != 2'd0);
   assign out_valid_1 = (cnt_q[1] != 2'd0);
   assign data_out_0  = out_valid_0 ? mem_q[0][rd_ptr_q[0]] : '0;
   assign data_out_1  = out_valid_1 ? mem_q[1][rd_ptr_q[1]] : '0;

endmodule
